// File: rtl/fetch_pf_if.sv
// rtl/fetch_pf_if.sv - redirect, instruction-memory and instruction-stream signals of the prefetch unit
interface fetch_pf_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 14
);
  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;
  logic              f_req;
  logic              f_gnt;
  logic [ADDR_W-1:0] f_mem_addr;
  logic [3:0]        f_mask;
  logic              f_wr_en;
  logic [XLEN-1:0]   f_w_data;
  logic              f_rvalid;
  logic [XLEN-1:0]   i_data;
  logic              inst_valid;
  logic [XLEN-1:0]   inst_data;
  logic [XLEN-1:0]   inst_pc;
  logic              inst_ready;
  logic              misalign;

  modport master (
    input  redirect, redirect_pc, f_gnt, f_rvalid, i_data, inst_ready,
    output f_req, f_mem_addr, f_mask, f_wr_en, f_w_data,
           inst_valid, inst_data, inst_pc, misalign
  );

  modport slave (
    output redirect, redirect_pc, f_gnt, f_rvalid, i_data, inst_ready,
    input  f_req, f_mem_addr, f_mask, f_wr_en, f_w_data,
           inst_valid, inst_data, inst_pc, misalign
  );
endinterface

// File: rtl/fetch_pf.sv
// rtl/fetch_pf.sv - prefetching instruction-fetch unit with credit-limited request issue and flush on redirect
module fetch_pf #(
  parameter int              XLEN     = 32,
  parameter int              ADDR_W   = 14,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic        clk,
  input logic        rst,
  fetch_pf_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  cnt_t            count_q, count_d;
  cnt_t            outstanding_q, outstanding_d;
  cnt_t            drop_q, drop_d;
  ptr_t            rd_ptr_q, rd_ptr_d;
  ptr_t            wr_ptr_q, wr_ptr_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] q_data_q [DEPTH];
  logic [XLEN-1:0] q_pc_q   [DEPTH];

  logic [CW:0] credit;
  logic        req;
  logic        grant;
  logic        rsp_ok;
  logic        push;
  logic        pop;

  // Outstanding requests plus buffered entries never exceed DEPTH, so a push always has room.
  always_comb begin
    credit = {1'b0, outstanding_q} + {1'b0, count_q};
    req    = !rst && !bus.redirect && !misalign_q && (credit < (CW+1)'(DEPTH));
    grant  = req && bus.f_gnt;
    rsp_ok = bus.f_rvalid && (outstanding_q != '0);
    push   = rsp_ok && (drop_q == '0) && !bus.redirect;
    pop    = (count_q != '0) && bus.inst_ready && !bus.redirect;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    misalign_d    = misalign_q;
    if (bus.redirect) begin
      // Every request still in flight belongs to the old path and must be discarded on return.
      fetch_pc_d    = bus.redirect_pc;
      resp_pc_d     = bus.redirect_pc;
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      outstanding_d = outstanding_q - cnt_t'(rsp_ok);
      drop_d        = outstanding_q - cnt_t'(rsp_ok);
      misalign_d    = (bus.redirect_pc[1:0] != 2'b00);
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      outstanding_d = outstanding_q + cnt_t'(grant) - cnt_t'(rsp_ok);
      if (rsp_ok && (drop_q != '0)) begin
        drop_d = drop_q - cnt_t'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + XLEN'(4);
        wr_ptr_d  = wr_ptr_q + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      misalign_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      misalign_q    <= misalign_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_data_q[wr_ptr_q] <= bus.i_data;
      q_pc_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

  assign bus.f_req      = req;
  assign bus.f_mem_addr = fetch_pc_q[ADDR_W+1:2];
  assign bus.f_mask     = 4'b1111;
  assign bus.f_wr_en    = 1'b0;
  assign bus.f_w_data   = '0;
  assign bus.inst_valid = !rst && (count_q != '0);
  assign bus.inst_data  = q_data_q[rd_ptr_q];
  assign bus.inst_pc    = q_pc_q[rd_ptr_q];
  assign bus.misalign   = misalign_q;
endmodule

// File: tb/tb_fetch_pf.sv
// tb/tb_fetch_pf.sv - directed self-checking bench for fetch_pf with an in-order variable-latency memory model
module tb_fetch_pf;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_pf_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  fetch_pf #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit rst_v = 1'b1;
  int gnt_lo, gnt_hi, lat_lo, lat_hi, gnt_wait;
  int rsp_q[$];
  int rsp_dly[$];

  logic              o_req, o_grant, o_pop, o_valid, o_mis;
  logic [ADDR_W-1:0] o_addr;
  logic [XLEN-1:0]   o_pc, o_data;

  function automatic logic [31:0] mem_word(input int a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  // One clock: drive inputs at the falling edge, sample 1 ns later, advance the memory model.
  task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc);
    @(negedge clk);
    rst             = rst_v;
    bus.inst_ready  = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.f_gnt       = (gnt_wait == 0);
    bus.f_rvalid    = 1'b0;
    bus.i_data      = '0;
    if (rsp_q.size() != 0 && rsp_dly[0] <= 0) begin
      bus.f_rvalid = 1'b1;
      bus.i_data   = mem_word(rsp_q[0]);
    end
    #1;
    o_req   = bus.f_req;
    o_addr  = bus.f_mem_addr;
    o_valid = bus.inst_valid;
    o_pc    = bus.inst_pc;
    o_data  = bus.inst_data;
    o_mis   = bus.misalign;
    o_grant = bus.f_req && bus.f_gnt;
    o_pop   = bus.inst_valid && rdy;
    if (bus.f_rvalid) begin
      void'(rsp_q.pop_front());
      void'(rsp_dly.pop_front());
    end
    foreach (rsp_dly[i]) rsp_dly[i] = rsp_dly[i] - 1;
    if (o_grant) begin
      rsp_q.push_back(int'(o_addr));
      rsp_dly.push_back(int'($urandom_range(lat_hi, lat_lo)) - 1);
      gnt_wait = int'($urandom_range(gnt_hi, gnt_lo));
    end else if (o_req && gnt_wait > 0) begin
      gnt_wait = gnt_wait - 1;
    end
  endtask

  task automatic set_mem(input int g_lo, input int g_hi, input int l_lo, input int l_hi);
    gnt_lo = g_lo; gnt_hi = g_hi; lat_lo = l_lo; lat_hi = l_hi;
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    rsp_q.delete();
    rsp_dly.delete();
    gnt_wait = 0;
    step(0, 0, 0);
    step(0, 0, 0);
    rst_v = 1'b0;
  endtask

  task automatic test_reset();
    set_mem(0, 0, 1, 1);
    do_reset();
    rst_v = 1'b1;
    step(0, 0, 0);
    n_checks++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", o_req); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", o_valid); end
    rst_v = 1'b0;
    step(0, 0, 0);
    n_checks++; if (o_req !== 1'b1) begin n_fail++; $display("FAIL post_rst_req got %b exp 1", o_req); end
    n_checks++; if (o_addr !== 14'h0) begin n_fail++; $display("FAIL post_rst_addr got %h exp 0", o_addr); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid got %b exp 0", o_valid); end
    n_checks++; if (o_mis !== 1'b0) begin n_fail++; $display("FAIL post_rst_misalign got %b exp 0", o_mis); end
    n_checks++; if (bus.f_mask !== 4'hF || bus.f_wr_en !== 1'b0 || bus.f_w_data !== 32'h0) begin
      n_fail++; $display("FAIL const_outs got mask=%h we=%b wd=%h exp F/0/0", bus.f_mask, bus.f_wr_en, bus.f_w_data);
    end
  endtask

  task automatic test_zero_wait();
    logic [XLEN-1:0] exp_pc [3];
    exp_pc = '{32'h0, 32'h4, 32'h8};
    set_mem(0, 0, 1, 1);
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step(1, 0, 0);
      if (c < 3) begin
        n_checks++; if (o_addr !== ADDR_W'(c) || o_grant !== 1'b1) begin
          n_fail++; $display("FAIL zw_addr cyc%0d got addr=%h gnt=%b exp addr=%h gnt=1", c, o_addr, o_grant, c);
        end
      end
      if (c < 2) begin
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL zw_early_valid cyc%0d got %b exp 0", c, o_valid); end
      end else begin
        n_checks++; if (o_valid !== 1'b1 || o_pc !== exp_pc[c-2] || o_data !== mem_word(c-2)) begin
          n_fail++; $display("FAIL zw_inst cyc%0d got v=%b pc=%h d=%h exp v=1 pc=%h d=%h",
                             c, o_valid, o_pc, o_data, exp_pc[c-2], mem_word(c-2));
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    int grants;
    set_mem(0, 0, 1, 1);
    do_reset();
    grants = 0;
    for (int c = 0; c < 10; c++) begin
      step(0, 0, 0);
      if (o_grant) grants++;
    end
    n_checks++; if (grants != 4) begin n_fail++; $display("FAIL bp_grants got %0d exp 4", grants); end
    n_checks++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_full got %b exp 0", o_req); end
    n_checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0) begin
      n_fail++; $display("FAIL bp_head got v=%b pc=%h exp v=1 pc=0", o_valid, o_pc);
    end
    step(1, 0, 0);
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      step(0, 0, 0);
      if (o_grant) grants++;
    end
    n_checks++; if (grants != 1) begin n_fail++; $display("FAIL bp_refill_grants got %0d exp 1", grants); end
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0);
      n_checks++; if (o_valid !== 1'b1 || o_pc !== 32'(4 * (k + 1))) begin
        n_fail++; $display("FAIL bp_drain%0d got v=%b pc=%h exp v=1 pc=%h", k, o_valid, o_pc, 4 * (k + 1));
      end
    end
  endtask

  task automatic test_redirect();
    bit found;
    set_mem(0, 0, 3, 3);
    do_reset();
    step(1, 0, 0);
    step(1, 0, 0);
    n_checks++; if (o_grant !== 1'b1 || o_addr !== 14'h1) begin
      n_fail++; $display("FAIL rd_second_grant got gnt=%b addr=%h exp 1/1", o_grant, o_addr);
    end
    step(1, 1, 32'h100);
    n_checks++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL rd_req_in_redirect got %b exp 0", o_req); end
    set_mem(0, 0, 1, 1);
    step(1, 0, 0);
    n_checks++; if (o_req !== 1'b1 || o_addr !== 14'h40) begin
      n_fail++; $display("FAIL rd_new_addr got req=%b addr=%h exp 1/40", o_req, o_addr);
    end
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1, 0, 0);
      if (o_valid) begin
        found = 1'b1;
        n_checks++; if (o_pc !== 32'h100 || o_data !== mem_word(32'h40)) begin
          n_fail++; $display("FAIL rd_first_inst got pc=%h d=%h exp pc=100 d=%h", o_pc, o_data, mem_word(32'h40));
        end
      end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL rd_timeout got no inst_valid exp one within 20 cycles"); end
  endtask

  task automatic test_redirect_rvalid_pop();
    bit found;
    set_mem(0, 0, 1, 1);
    do_reset();
    step(0, 0, 0);
    set_mem(0, 0, 3, 3);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    n_checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0) begin
      n_fail++; $display("FAIL rrp_head got v=%b pc=%h exp v=1 pc=0", o_valid, o_pc);
    end
    step(1, 1, 32'h300);
    n_checks++; if (o_req !== 1'b0 || o_pop !== 1'b1) begin
      n_fail++; $display("FAIL rrp_redirect_cycle got req=%b pop=%b exp 0/1", o_req, o_pop);
    end
    set_mem(0, 0, 1, 1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1, 0, 0);
      if (o_valid) begin
        found = 1'b1;
        n_checks++; if (o_pc !== 32'h300 || o_data !== mem_word(32'hC0)) begin
          n_fail++; $display("FAIL rrp_first_inst got pc=%h d=%h exp pc=300 d=%h", o_pc, o_data, mem_word(32'hC0));
        end
      end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL rrp_timeout got no inst_valid exp one within 20 cycles"); end
    step(1, 0, 0);
    n_checks++; if (o_valid !== 1'b1 || o_pc !== 32'h304) begin
      n_fail++; $display("FAIL rrp_second_inst got v=%b pc=%h exp v=1 pc=304", o_valid, o_pc);
    end
  endtask

  task automatic test_misalign();
    bit found;
    set_mem(0, 0, 1, 1);
    do_reset();
    repeat (3) step(1, 0, 0);
    step(1, 1, 32'h102);
    n_checks++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL mis_req_redirect got %b exp 0", o_req); end
    for (int c = 0; c < 8; c++) begin
      step(1, 0, 0);
      n_checks++; if (o_mis !== 1'b1 || o_req !== 1'b0) begin
        n_fail++; $display("FAIL mis_hold cyc%0d got mis=%b req=%b exp 1/0", c, o_mis, o_req);
      end
    end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mis_valid got %b exp 0", o_valid); end
    step(1, 1, 32'h200);
    step(1, 0, 0);
    n_checks++; if (o_mis !== 1'b0 || o_req !== 1'b1 || o_addr !== 14'h80) begin
      n_fail++; $display("FAIL mis_clear got mis=%b req=%b addr=%h exp 0/1/80", o_mis, o_req, o_addr);
    end
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1, 0, 0);
      if (o_valid) begin
        found = 1'b1;
        n_checks++; if (o_pc !== 32'h200 || o_data !== mem_word(32'h80)) begin
          n_fail++; $display("FAIL mis_resume got pc=%h d=%h exp pc=200 d=%h", o_pc, o_data, mem_word(32'h80));
        end
      end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL mis_timeout got no inst_valid exp one within 20 cycles"); end
  endtask

  task automatic test_variable_latency();
    logic [XLEN-1:0]   exp_pc;
    logic [ADDR_W-1:0] prev_addr;
    bit                prev_stall;
    bit                rdy;
    int                pops;
    set_mem(0, 3, 1, 5);
    do_reset();
    exp_pc     = 32'h0;
    pops       = 0;
    prev_stall = 1'b0;
    prev_addr  = '0;
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(3, 0) != 0);
      step(rdy, 0, 0);
      if (prev_stall && o_req) begin
        n_checks++; if (o_addr !== prev_addr) begin
          n_fail++; $display("FAIL var_addr_stable cyc%0d got %h exp %h", c, o_addr, prev_addr);
        end
      end
      prev_stall = o_req && !o_grant;
      prev_addr  = o_addr;
      if (o_pop) begin
        n_checks++; if (o_pc !== exp_pc || o_data !== mem_word(int'(exp_pc >> 2))) begin
          n_fail++; $display("FAIL var_stream got pc=%h d=%h exp pc=%h d=%h",
                             o_pc, o_data, exp_pc, mem_word(int'(exp_pc >> 2)));
        end
        exp_pc = exp_pc + 32'h4;
        pops++;
      end
    end
    n_checks++; if (pops < 20) begin n_fail++; $display("FAIL var_progress got %0d pops exp >= 20", pops); end
  endtask

  initial begin
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.f_gnt       = 1'b0;
    bus.f_rvalid    = 1'b0;
    bus.i_data      = '0;
    bus.inst_ready  = 1'b0;
    test_reset();
    test_zero_wait();
    test_back_pressure();
    test_redirect();
    test_redirect_rvalid_pop();
    test_misalign();
    test_variable_latency();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
